// File: rtl/result_buffer_pkg.sv
// Shared definitions for multi_chan_result_buffer: register map, STATUS layout,
// prefetch FSM encoding, read sentinel and the seven-segment helper.
package result_buffer_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_UNF_BIT   = 3;

    localparam int CTRL_FLUSH_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    localparam logic [31:0] UNDERFLOW_WORD = 32'hFFFF_FFFF;

    localparam logic [1:0] PF_EMPTY = 2'd0;
    localparam logic [1:0] PF_FETCH = 2'd1;
    localparam logic [1:0] PF_VALID = 2'd2;

    // Field order matches the STATUS bit positions above (unf is bit 3).
    typedef struct packed {
        logic unf;
        logic ovf;
        logic full;
        logic empty;
    } status_t;

    function automatic logic [7:0] seg7(input logic [1:0] value);
        logic [7:0] pattern;
        case (value)
            2'd0:    pattern = 8'd63;
            2'd1:    pattern = 8'd6;
            2'd2:    pattern = 8'd91;
            default: pattern = 8'd79;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/rb_channel.sv
// One result channel: DEPTH-word RAM FIFO with a show-ahead head register fed
// by a prefetch FSM. Defining HEX_DISPLAY_EN adds the seven-segment output.
module rb_channel
    import result_buffer_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 16384,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_en,
    input  logic [DW-1:0] push_data,
    input  logic          data_rd,
    input  logic          flush,
    input  logic          clear_sticky,
    output logic [DW-1:0] head,
    output logic [AW:0]   count,
    output status_t       status,
    output logic [1:0]    state
`ifdef HEX_DISPLAY_EN
    ,
    output logic [7:0]    hex_seg
`endif
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q;
    logic [DW-1:0] head_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic [AW:0]   count_q;
    logic [1:0]    state_q;
    logic          pend;
    logic          ovf_q;
    logic          unf_q;

    logic full;
    logic head_valid;
    logic accept;
    logic pop;
    logic ram_rd;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign head_valid = (state_q == PF_VALID);
    assign accept     = push_en && (push_data != '0) && !full && !flush;
    assign pop        = data_rd && head_valid && !flush;
    // RAM read is issued on the first FETCH cycle; the second cycle loads the head.
    assign ram_rd     = (state_q == PF_FETCH) && !pend && !flush;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
        if (ram_rd) begin
            ram_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            count_q <= '0;
            head_q  <= '0;
            state_q <= PF_EMPTY;
            pend    <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            count_q <= '0;
            state_q <= PF_EMPTY;
            pend    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({accept, ram_rd})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase

            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            case (state_q)
                PF_EMPTY: begin
                    if (ram_cnt != '0) begin
                        state_q <= PF_FETCH;
                    end
                end
                PF_FETCH: begin
                    if (pend) begin
                        head_q  <= ram_q;
                        state_q <= PF_VALID;
                        pend    <= 1'b0;
                    end else begin
                        pend <= 1'b1;
                    end
                end
                PF_VALID: begin
                    if (pop) begin
                        state_q <= (ram_cnt != '0) ? PF_FETCH : PF_EMPTY;
                    end
                end
                default: begin
                    state_q <= PF_EMPTY;
                    pend    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags survive a flush; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (clear_sticky) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end
            if (push_en && (push_data != '0) && full && !flush) begin
                ovf_q <= 1'b1;
            end
            if (data_rd && !head_valid) begin
                unf_q <= 1'b1;
            end
        end
    end

`ifdef HEX_DISPLAY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_seg <= '0;
        end else begin
            hex_seg <= accept ? seg7(push_data[1:0]) : 8'd0;
        end
    end
`endif

    assign head         = head_q;
    assign count        = count_q;
    assign state        = state_q;
    assign status.unf   = unf_q;
    assign status.ovf   = ovf_q;
    assign status.full  = full;
    assign status.empty = !head_valid;

endmodule

// File: rtl/multi_chan_result_buffer.sv
// NCH independent result FIFOs behind one Avalon-MM slave with fixed read latency 1.
// Defining HEX_DISPLAY_EN adds the per-channel seven-segment hex port.
module multi_chan_result_buffer
    import result_buffer_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int DW     = 8,
    parameter int DEPTH  = 16384,
    localparam int AW    = $clog2(DEPTH),
    localparam int ABITS = 2 + $clog2(NCH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH-1:0]    wr_en,
    input  logic [NCH*DW-1:0] wr_data,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [ABITS-1:0]  address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata
`ifdef HEX_DISPLAY_EN
    ,
    output logic [NCH*8-1:0]  hex
`endif
);

    logic [3:0]    sel_ch;
    logic [1:0]    sel_reg;
    logic          ch_ok;
    logic          rd_req;
    logic          wr_req;
    logic [31:0]   rd_mux;
    logic          ctrl_unused;

    logic [DW-1:0] head     [NCH];
    logic [AW:0]   count    [NCH];
    status_t       status   [NCH];
    logic [1:0]    ch_state [NCH];

    assign sel_reg     = address[1:0];
    assign sel_ch      = 4'(address >> 2);
    assign ch_ok       = (sel_ch < 4'(NCH));
    assign rd_req      = chipselect && read && ch_ok;
    assign wr_req      = chipselect && write && ch_ok;
    assign ctrl_unused = ^writedata[31:2];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic hit;
        logic data_rd;
        logic flush;
        logic clear_sticky;

        assign hit          = (sel_ch == 4'(c));
        assign data_rd      = rd_req && hit && (sel_reg == REG_DATA);
        assign flush        = wr_req && hit && (sel_reg == REG_CTRL) && writedata[CTRL_FLUSH_BIT];
        assign clear_sticky = wr_req && hit && (sel_reg == REG_CTRL) && writedata[CTRL_CLEAR_BIT];

        rb_channel #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_channel (
            .clk          (clk),
            .reset_n      (reset_n),
            .push_en      (wr_en[c]),
            .push_data    (wr_data[c*DW +: DW]),
            .data_rd      (data_rd),
            .flush        (flush),
            .clear_sticky (clear_sticky),
            .head         (head[c]),
            .count        (count[c]),
            .status       (status[c]),
            .state        (ch_state[c])
`ifdef HEX_DISPLAY_EN
            ,
            .hex_seg      (hex[c*8 +: 8])
`endif
        );
    end

    // A DATA read while the head is not loaded returns the sentinel instead.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NCH; c++) begin
            if (sel_ch == 4'(c)) begin
                case (sel_reg)
                    REG_DATA:   rd_mux = (ch_state[c] == PF_VALID) ? 32'(head[c]) : UNDERFLOW_WORD;
                    REG_COUNT:  rd_mux = 32'(count[c]);
                    REG_STATUS: rd_mux = 32'(status[c]);
                    default:    rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_req) begin
            readdata <= rd_mux;
        end else begin
            readdata <= '0;
        end
    end

endmodule

// File: tb/tb_multi_chan_result_buffer.sv
// Bench for multi_chan_result_buffer (NCH=3, DW=8, DEPTH=4): directed vector table,
// hand sequences for latency/wrap/flush/reset, and randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_multi_chan_result_buffer;
    import result_buffer_pkg::*;

    localparam int NCH   = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int ABITS = 2 + $clog2(NCH);

    localparam int OP_PUSH = 0;
    localparam int OP_READ = 1;
    localparam int OP_CTRL = 2;

    typedef struct {
        int          op;
        int          ch;
        int          arg;
        logic [31:0] exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    wr_en;
    logic [NCH*DW-1:0] wr_data;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [ABITS-1:0]  address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
`ifdef HEX_DISPLAY_EN
    logic [NCH*8-1:0]  hex;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q [NCH][$];
    logic          ovf_m [NCH];
    logic          unf_m [NCH];

    vec_t vecs[$];

    always #5 clk = ~clk;

    multi_chan_result_buffer #(
        .NCH   (NCH),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata)
`ifdef HEX_DISPLAY_EN
        ,
        .hex        (hex)
`endif
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            exp_q[c].delete();
            ovf_m[c] = 1'b0;
            unf_m[c] = 1'b0;
        end
    endfunction

    function automatic void model_push(input int ch, input logic [DW-1:0] d);
        if (d == '0) return;
        if (exp_q[ch].size() == DEPTH) ovf_m[ch] = 1'b1;
        else exp_q[ch].push_back(d);
    endfunction

    function automatic void model_ctrl(input int ch, input logic [31:0] v);
        if (ch >= NCH) return;
        if (v[CTRL_FLUSH_BIT]) exp_q[ch].delete();
        if (v[CTRL_CLEAR_BIT]) begin
            ovf_m[ch] = 1'b0;
            unf_m[ch] = 1'b0;
        end
    endfunction

    function automatic logic [31:0] model_read(input int ch, input logic [1:0] rg);
        logic [31:0] r;
        r = '0;
        if (ch < NCH) begin
            case (rg)
                REG_DATA: begin
                    if (exp_q[ch].size() == 0) begin
                        unf_m[ch] = 1'b1;
                        r = 32'hFFFF_FFFF;
                    end else begin
                        r = 32'(exp_q[ch].pop_front());
                    end
                end
                REG_COUNT: r = 32'(exp_q[ch].size());
                REG_STATUS: begin
                    r[STAT_EMPTY_BIT] = (exp_q[ch].size() == 0);
                    r[STAT_FULL_BIT]  = (exp_q[ch].size() == DEPTH);
                    r[STAT_OVF_BIT]   = ovf_m[ch];
                    r[STAT_UNF_BIT]   = unf_m[ch];
                end
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [NCH*DW-1:0] pack_word(input int ch, input logic [DW-1:0] d);
        logic [NCH*DW-1:0] w;
        w = '0;
        w[ch*DW +: DW] = d;
        return w;
    endfunction

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One clock of stimulus, driven at a falling edge; returns readdata sampled at the next one.
    task automatic bus_cycle(input logic do_rd, input logic do_wr, input int ch, input logic [1:0] rg,
                             input logic [31:0] wdat, input logic [NCH-1:0] we,
                             input logic [NCH*DW-1:0] wd, output logic [31:0] rdat);
        chipselect = do_rd | do_wr;
        read       = do_rd;
        write      = do_wr;
        address    = ABITS'(ch * 4 + int'(rg));
        writedata  = wdat;
        wr_en      = we;
        wr_data    = wd;
        @(negedge clk);
        rdat       = readdata;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        wr_en      = '0;
        wr_data    = '0;
    endtask

    task automatic do_push(input int ch, input logic [DW-1:0] d);
        logic [31:0] dummy;
        model_push(ch, d);
        bus_cycle(1'b0, 1'b0, 0, REG_DATA, 32'd0, NCH'(1 << ch), pack_word(ch, d), dummy);
    endtask

    task automatic do_ctrl(input int ch, input logic [31:0] v);
        logic [31:0] dummy;
        model_ctrl(ch, v);
        bus_cycle(1'b0, 1'b1, ch, REG_CTRL, v, '0, '0, dummy);
    endtask

    // Settled register read against the model, then readdata must fall back to 0.
    task automatic do_read(input int ch, input logic [1:0] rg, input string name);
        logic [31:0] got;
        logic [31:0] exp;
        idle(3);
        exp = model_read(ch, rg);
        bus_cycle(1'b1, 1'b0, ch, rg, 32'd0, '0, '0, got);
        check(name, got, exp);
        @(negedge clk);
        check({name, "_idle"}, readdata, 32'd0);
    endtask

    initial begin
        logic [31:0]       got;
        logic [31:0]       exp;
        logic [NCH-1:0]    m;
        logic [NCH*DW-1:0] wd;
        logic [DW-1:0]     d;
        vec_t              v;

        reset_n    = 1'b0;
        wr_en      = '0;
        wr_data    = '0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        model_reset();
        idle(3);
        check("reset_readdata", readdata, 32'd0);
        reset_n = 1'b1;

        // ---------------- directed vector table ----------------
        vecs.push_back('{OP_READ, 0, int'(REG_COUNT),  32'd0});
        vecs.push_back('{OP_READ, 0, int'(REG_STATUS), 32'd1});
        vecs.push_back('{OP_READ, 1, int'(REG_STATUS), 32'd1});
        vecs.push_back('{OP_READ, 2, int'(REG_COUNT),  32'd0});
        vecs.push_back('{OP_READ, 2, int'(REG_STATUS), 32'd1});
        vecs.push_back('{OP_READ, 3, int'(REG_STATUS), 32'd0});
        vecs.push_back('{OP_READ, 3, int'(REG_DATA),   32'd0});
        vecs.push_back('{OP_PUSH, 1, 5, 32'd0});
        vecs.push_back('{OP_PUSH, 1, 7, 32'd0});
        vecs.push_back('{OP_PUSH, 1, 9, 32'd0});
        vecs.push_back('{OP_READ, 1, int'(REG_COUNT),  32'd3});
        vecs.push_back('{OP_READ, 1, int'(REG_STATUS), 32'd0});
        vecs.push_back('{OP_READ, 1, int'(REG_DATA),   32'd5});
        vecs.push_back('{OP_READ, 1, int'(REG_DATA),   32'd7});
        vecs.push_back('{OP_READ, 1, int'(REG_DATA),   32'd9});
        vecs.push_back('{OP_READ, 1, int'(REG_DATA),   32'hFFFF_FFFF});
        vecs.push_back('{OP_READ, 1, int'(REG_STATUS), 32'd9});
        vecs.push_back('{OP_CTRL, 1, 2, 32'd0});
        vecs.push_back('{OP_READ, 1, int'(REG_STATUS), 32'd1});
        for (int i = 1; i <= 6; i++) vecs.push_back('{OP_PUSH, 0, i, 32'd0});
        vecs.push_back('{OP_READ, 0, int'(REG_COUNT),  32'd4});
        vecs.push_back('{OP_READ, 0, int'(REG_STATUS), 32'd6});
        for (int i = 1; i <= 4; i++) vecs.push_back('{OP_READ, 0, int'(REG_DATA), 32'(i)});
        vecs.push_back('{OP_READ, 0, int'(REG_STATUS), 32'd5});
        vecs.push_back('{OP_CTRL, 0, 2, 32'd0});
        vecs.push_back('{OP_READ, 0, int'(REG_STATUS), 32'd1});
        vecs.push_back('{OP_PUSH, 2, 0, 32'd0});
        vecs.push_back('{OP_READ, 2, int'(REG_COUNT),  32'd0});
        vecs.push_back('{OP_READ, 2, int'(REG_STATUS), 32'd1});
        vecs.push_back('{OP_CTRL, 3, 3, 32'd0});
        vecs.push_back('{OP_READ, 3, int'(REG_COUNT),  32'd0});
        vecs.push_back('{OP_READ, 0, int'(REG_STATUS), 32'd1});

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            case (v.op)
                OP_PUSH: do_push(v.ch, DW'(v.arg));
                OP_CTRL: do_ctrl(v.ch, 32'(v.arg));
                default: begin
                    idle(3);
                    exp = model_read(v.ch, 2'(v.arg));
                    bus_cycle(1'b1, 1'b0, v.ch, 2'(v.arg), 32'd0, '0, '0, got);
                    check($sformatf("vec%0d_ch%0d_reg%0d", i, v.ch, v.arg), got, v.exp);
                end
            endcase
        end

        // ---------------- push-to-poppable latency ----------------
        do_ctrl(0, 32'd3);
        idle(2);
        do_push(0, 8'h21);
        idle(2);
        bus_cycle(1'b1, 1'b0, 0, REG_STATUS, 32'd0, '0, '0, got);
        check("latency_edge_t3_empty", got, 32'd1);
        bus_cycle(1'b1, 1'b0, 0, REG_STATUS, 32'd0, '0, '0, got);
        check("latency_edge_t4_ready", got, 32'd0);
        do_read(0, REG_DATA, "latency_data");

        // ---------------- same-cycle push+pop across pointer wrap ----------------
        do_ctrl(0, 32'd3);
        for (int i = 0; i < 3; i++) do_push(0, DW'(8'h40 + i));
        idle(3);
        for (int i = 0; i < 20; i++) begin
            d   = DW'($urandom_range(1, 255));
            exp = model_read(0, REG_DATA);
            model_push(0, d);
            bus_cycle(1'b1, 1'b0, 0, REG_DATA, 32'd0, 3'b001, pack_word(0, d), got);
            check($sformatf("wrap_data%0d", i), got, exp);
            bus_cycle(1'b1, 1'b0, 0, REG_COUNT, 32'd0, '0, '0, got);
            check($sformatf("wrap_count%0d", i), got, 32'd3);
            idle(1);
        end
        do_read(0, REG_COUNT, "wrap_final_count");

        // ---------------- flush with concurrent push ----------------
        do_ctrl(1, 32'd3);
        do_read(1, REG_DATA, "flush_pre_unf");
        do_ctrl(0, 32'd1);
        do_ctrl(2, 32'd3);
        m = 3'b111;
        wd = {8'h31, 8'h11, 8'h0A};
        model_push(0, 8'h0A);
        model_push(1, 8'h11);
        model_push(2, 8'h31);
        bus_cycle(1'b0, 1'b0, 0, REG_DATA, 32'd0, m, wd, got);
        do_push(1, 8'h12);
        do_push(1, 8'h13);
        do_read(1, REG_COUNT, "flush_pre_count");
        model_ctrl(1, 32'd1);
        bus_cycle(1'b0, 1'b1, 1, REG_CTRL, 32'd1, 3'b010, pack_word(1, 8'h77), got);
        do_read(1, REG_COUNT,  "flush_count");
        do_read(1, REG_STATUS, "flush_status");
        do_read(0, REG_COUNT,  "flush_ch0_count");
        do_read(2, REG_COUNT,  "flush_ch2_count");
        do_read(0, REG_DATA,   "flush_ch0_data");
        do_read(2, REG_DATA,   "flush_ch2_data");
        do_read(1, REG_DATA,   "flush_ch1_data");

        // ---------------- randomized traffic against the model ----------------
        for (int it = 0; it < 160; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    m  = NCH'($urandom_range(1, (1 << NCH) - 1));
                    wd = '0;
                    for (int c = 0; c < NCH; c++) begin
                        d = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(1, 255));
                        wd[c*DW +: DW] = d;
                        if (m[c]) model_push(c, d);
                    end
                    bus_cycle(1'b0, 1'b0, 0, REG_DATA, 32'd0, m, wd, got);
                end
                4, 5, 6, 7: do_read($urandom_range(0, 3), 2'($urandom_range(0, 2)),
                                    $sformatf("rand%0d", it));
                8:       do_ctrl($urandom_range(0, 2), 32'd2);
                default: do_ctrl($urandom_range(0, 2), 32'($urandom_range(1, 3)));
            endcase
        end
        for (int c = 0; c < NCH; c++) do_read(c, REG_STATUS, $sformatf("rand_end_status%0d", c));

        // ---------------- reset mid-stream ----------------
        m  = 3'b111;
        wd = {8'h23, 8'h22, 8'h21};
        bus_cycle(1'b0, 1'b0, 0, REG_DATA, 32'd0, m, wd, got);
        bus_cycle(1'b0, 1'b0, 0, REG_DATA, 32'd0, m, wd, got);
        idle(3);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = ABITS'(int'(REG_DATA));
        #2 reset_n = 1'b0;
        #1 check("reset_async_readdata", readdata, 32'd0);
        @(negedge clk);
        check("reset_read_discarded", readdata, 32'd0);
        chipselect = 1'b0;
        read       = 1'b0;
        address    = '0;
        idle(2);
        reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < NCH; c++) begin
            do_read(c, REG_COUNT,  $sformatf("post_reset_count%0d", c));
            do_read(c, REG_STATUS, $sformatf("post_reset_status%0d", c));
        end

`ifdef HEX_DISPLAY_EN
        check("hex_after_reset", 32'(hex), 32'd0);
        do_push(2, 8'h00);
        check("hex_zero_push", 32'(hex[23:16]), 32'd0);
        do_push(2, 8'h0B);
        check("hex_push_ch2", 32'(hex[23:16]), 32'd79);
        @(negedge clk);
        check("hex_no_push", 32'(hex[23:16]), 32'd0);
        do_push(0, 8'h02);
        check("hex_push_ch0", 32'(hex[7:0]), 32'd91);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_chan_result_buffer.md
MULTI_CHAN_RESULT_BUFFER -- requirements
Module: multi_chan_result_buffer

Interface
REQ-001 SHALL have parameter NCH, default 3, number of independent result channels (1..8).
REQ-002 SHALL have parameter DW, default 8, result word width (2..32).
REQ-003 SHALL have parameter DEPTH, default 16384, words per channel (power of two, >=4); AW = clog2(DEPTH).
REQ-004 SHALL have port clk  in  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port wr_en  in  NCH  per-channel push strobe.
REQ-007 SHALL have port wr_data  in  NCH*DW  per-channel result word; channel c occupies bits [c*DW +: DW].
REQ-008 SHALL have port chipselect  in  1  Avalon-MM slave select.
REQ-009 SHALL have ports read / write  in  1 each  Avalon-MM strobes.
REQ-010 SHALL have port address  in  2+clog2(NCH)  register index: channel = address[MSB:2], register = address[1:0].
REQ-011 SHALL have port writedata  in  32  CTRL write data.
REQ-012 SHALL have port readdata  out  32  registered read data.
REQ-013 SHALL have port hex  out  NCH*8  per-channel seven-segment pattern (present only with HEX_DISPLAY_EN).

Function
REQ-014 SHALL give each channel an independent FIFO of DEPTH words in inferred simple dual-port RAM (1-cycle read latency), plus a one-word show-ahead head register.
REQ-015 SHALL push on wr_en[c]=1 only when wr_data word is non-zero and channel not full; zero words are dropped silently.
REQ-016 SHALL drop a push when the channel is full and set sticky OVF[c]; stored data is unchanged.
REQ-017 SHALL run a per-channel prefetch FSM: EMPTY -> FETCH (RAM word pending) -> VALID (head loaded) -> FETCH on pop if more words are stored, else EMPTY.
REQ-018 SHALL make a word pushed into an empty channel at edge t poppable (STATUS.empty=0) after edge t+3.
REQ-019 SHALL use register map per channel: 0 DATA (read = pop), 1 COUNT (occupancy incl. head, AW+1 bits), 2 STATUS {bit3 UNF, bit2 OVF, bit1 full, bit0 empty}, 3 CTRL (write: bit0 flush, bit1 clear stickies).
REQ-020 SHALL return readdata one cycle after chipselect&&read (fixed read latency 1); a DATA read pops exactly one word; no two-phase read.
REQ-021 SHALL return 32'hFFFF_FFFF and set sticky UNF[c] on a DATA read while empty; no pointer changes.
REQ-022 SHALL return 0 for addresses whose channel index >= NCH and ignore writes to them.
REQ-023 SHALL, on push and pop of the same channel in one cycle, perform both; COUNT unchanged.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; full = COUNT==DEPTH, empty = head not valid.
REQ-025 SHALL, on CTRL flush, clear that channel's pointers, COUNT and head in one cycle; a simultaneous push is discarded; stickies retained unless bit1 also set.
REQ-026 SHALL hold readdata at 0 when no read is active.

Reset
REQ-027 SHALL, on reset_n low, immediately clear all pointers, COUNT, head valid, OVF, UNF, readdata, hex; FSMs to EMPTY; RAM contents undefined.
REQ-028 SHALL, if reset asserts mid-read, discard the read.

Configuration
REQ-029 SHALL, with HEX_DISPLAY_EN defined, drive hex[c] with the seven-segment encoding of the low 2 bits of the last accepted push of channel c (00=63, 01=6, 10=91, 11=79), and 0 in cycles with no accepted push.
REQ-030 SHALL, without HEX_DISPLAY_EN, omit the hex port and all its logic.

Structure
REQ-031 SHALL place register offsets, STATUS bit positions, the 32'hFFFF_FFFF sentinel and the seven-segment function in package result_buffer_pkg.
REQ-032 SHALL implement one channel (RAM, pointers, prefetch FSM, flags) as sub-module rb_channel, instantiated NCH times via generate.

Verification
REQ-033 SHALL cover: push 5,7,9 on ch1 -> after 3 cycles COUNT=3; three DATA reads return 5,7,9; the fourth returns FFFF_FFFF and sets UNF.
REQ-034 SHALL cover: DEPTH=4, push 1..6 on ch0 -> COUNT=4, full=1, OVF=1; reads return 1,2,3,4.
REQ-035 SHALL cover: push of 0 on ch2 -> COUNT stays 0; hex unchanged from blank.
REQ-036 SHALL cover: sustained push and pop on ch0 in the same cycles across pointer wrap (DEPTH=4, 20 words) -> data in order, COUNT constant.
REQ-037 SHALL cover: CTRL flush of ch1 with 3 words stored and concurrent push -> COUNT=0, empty=1, other channels unaffected.
REQ-038 SHALL cover: reset_n pulsed mid-stream -> all COUNT=0, STATUS=0x1, readdata=0.
